sb_reg_slave: RTL and testbench

- Parametrised, synthesizable iCE40 system-bus (SB) slave: strobe/ack bus interface in front of a register bank, status input and interrupt controller.
- Successor to the single-cycle SB_SPI ack model. Adds configurable ack latency, a base-address decode, a read/write register file, a read-only status register and a maskable, write-1-to-clear IRQ.
- Sits beside the hard SPI/I2C IP on the same SB bus. Used by spi_slave_controller-style masters and their benches.

---
 rtl/sb_reg_slave.sv | 181 ++++++++++++++++++
 tb/tb_sb_reg_slave.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/sb_reg_slave.sv
// sb_reg_slave: system-bus slave with strobe/ack handshake, configurable ack
// latency, base-nibble decode, RW control registers, read-only status and a
// maskable write-1-to-clear interrupt.
//
// Handshake: a transaction starts on a rising edge of SBSTBi seen while IDLE
// and addressed to BASE_NIB. SBWRi/SBADRi/SBDATi are captured at that edge.
// SBACKo is high for exactly one cycle, ACK_LAT cycles later. SBDATo carries
// read data only while SBACKo is high and is 0 otherwise. A write commits at
// the clock edge that ends the ack cycle. Strobe edges seen while busy are
// dropped, and SBSTBi falling early does not cancel a transaction.
module sb_reg_slave #(
  parameter int                DATA_W   = 8,
  parameter logic [3:0]        BASE_NIB = 4'b0000,
  parameter int                NUM_REGS = 4,
  parameter int                ACK_LAT  = 1,
  parameter logic [DATA_W-1:0] RST_VAL  = '0
) (
  input  logic                       SBCLKi,
  input  logic                       RST,
  input  logic                       SBWRi,
  input  logic                       SBSTBi,
  input  logic [7:0]                 SBADRi,
  input  logic [DATA_W-1:0]          SBDATi,
  output logic [DATA_W-1:0]          SBDATo,
  output logic                       SBACKo,
  output logic                       IRQ,
  output logic [NUM_REGS*DATA_W-1:0] CTRL_O,
  input  logic [DATA_W-1:0]          STATUS_I,
  input  logic [DATA_W-1:0]          EVT_I,
  output logic [1:0]                 dbg_state
);

  // Parameter range checks, evaluated at elaboration.
  if (NUM_REGS < 1 || NUM_REGS > 13) begin : g_bad_num_regs
    $error("sb_reg_slave: NUM_REGS must be 1..13");
  end
  if (DATA_W < 1 || DATA_W > 16) begin : g_bad_data_w
    $error("sb_reg_slave: DATA_W must be 1..16");
  end
  if (ACK_LAT < 1 || ACK_LAT > 15) begin : g_bad_ack_lat
    $error("sb_reg_slave: ACK_LAT must be 1..15");
  end

  localparam logic [3:0] OFF_IEN    = 4'hD;
  localparam logic [3:0] OFF_STATUS = 4'hE;
  localparam logic [3:0] OFF_PEND   = 4'hF;
  localparam logic [3:0] LAT_M1     = 4'(ACK_LAT - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_ACK  = 2'd2
  } state_t;

  state_t            state_q;
  logic              stb_d;
  logic              wr_q;
  logic [3:0]        off_q;
  logic [DATA_W-1:0] dat_q;
  logic [3:0]        cnt_q;
  logic              ack_q;

  logic [DATA_W-1:0] ctrl_q [NUM_REGS];
  logic [DATA_W-1:0] ien_q;
  logic [DATA_W-1:0] pend_q;
  logic              irq_q;

  logic              stb_edge;
  logic              hit;
  logic              commit;
  logic [DATA_W-1:0] clr;
  logic [DATA_W-1:0] ien_next;
  logic [DATA_W-1:0] pend_next;
  logic [DATA_W-1:0] rd_mux;

  assign stb_edge = SBSTBi & ~stb_d;
  assign hit      = (SBADRi[7:4] == BASE_NIB);
  // Writes take effect on the edge that leaves the ack cycle.
  assign commit   = (state_q == ST_ACK) && wr_q;

  // Bus FSM: strobe edge detect, capture, latency countdown, one-cycle ack.
  always_ff @(posedge SBCLKi or negedge RST) begin
    if (!RST) begin
      state_q <= ST_IDLE;
      stb_d   <= 1'b0;
      wr_q    <= 1'b0;
      off_q   <= 4'h0;
      dat_q   <= '0;
      cnt_q   <= 4'h0;
      ack_q   <= 1'b0;
    end else begin
      stb_d <= SBSTBi;
      unique case (state_q)
        ST_IDLE: begin
          if (stb_edge && hit) begin
            wr_q  <= SBWRi;
            off_q <= SBADRi[3:0];
            dat_q <= SBDATi;
            cnt_q <= LAT_M1;
            if (ACK_LAT == 1) begin
              state_q <= ST_ACK;
              ack_q   <= 1'b1;
            end else begin
              state_q <= ST_WAIT;
            end
          end
        end
        ST_WAIT: begin
          if (cnt_q == 4'd1) begin
            state_q <= ST_ACK;
            ack_q   <= 1'b1;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        ST_ACK: begin
          state_q <= ST_IDLE;
          ack_q   <= 1'b0;
        end
        default: begin
          state_q <= ST_IDLE;
          ack_q   <= 1'b0;
        end
      endcase
    end
  end

  // Control registers and interrupt enable, written on commit.
  always_ff @(posedge SBCLKi or negedge RST) begin
    if (!RST) begin
      for (int k = 0; k < NUM_REGS; k++) ctrl_q[k] <= RST_VAL;
      ien_q <= '0;
    end else begin
      for (int k = 0; k < NUM_REGS; k++) begin
        if (commit && off_q == 4'(k)) ctrl_q[k] <= dat_q;
      end
      ien_q <= ien_next;
    end
  end

  // Next-state of IEN/PEND; an event on the clear cycle keeps its bit set.
  always_comb begin
    clr      = '0;
    ien_next = ien_q;
    if (commit && off_q == OFF_PEND) clr = dat_q;
    if (commit && off_q == OFF_IEN)  ien_next = dat_q;
    pend_next = (pend_q & ~clr) | EVT_I;
  end

  // Pending bits and registered interrupt output.
  always_ff @(posedge SBCLKi or negedge RST) begin
    if (!RST) begin
      pend_q <= '0;
      irq_q  <= 1'b0;
    end else begin
      pend_q <= pend_next;
      irq_q  <= |(pend_next & ien_next);
    end
  end

  // Read mux over the captured offset; unmapped offsets read as 0.
  always_comb begin
    rd_mux = '0;
    for (int k = 0; k < NUM_REGS; k++) begin
      if (off_q == 4'(k)) rd_mux = ctrl_q[k];
    end
    if (off_q == OFF_IEN)    rd_mux = ien_q;
    if (off_q == OFF_STATUS) rd_mux = STATUS_I;
    if (off_q == OFF_PEND)   rd_mux = pend_q;
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_ctrl_flat
    assign CTRL_O[g*DATA_W +: DATA_W] = ctrl_q[g];
  end

  assign SBACKo    = ack_q;
  assign SBDATo    = ack_q ? rd_mux : '0;
  assign IRQ       = irq_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_sb_reg_slave.sv
// Bench for sb_reg_slave: two instances (ACK_LAT=1 and ACK_LAT=4) share the
// bus inputs; each has its own event input so pulses can be timed to each
// instance's commit edge. Expected values are hand-computed constants.
module tb_sb_reg_slave;

  logic        clk;
  logic        rst_n;
  logic        sbwr;
  logic        sbstb;
  logic [7:0]  sbadr;
  logic [7:0]  sbdat;
  logic [7:0]  status_i;
  logic [7:0]  evt1;
  logic [7:0]  evt4;

  logic [7:0]  dato1, dato4;
  logic        ack1, ack4;
  logic        irq1, irq4;
  logic [31:0] ctrl1, ctrl4;
  logic [1:0]  st1, st4;

  int checks;
  int errors;

  // Results of the last transaction, filled by xfer().
  int          lat1, lat4, cnt1, cnt4, irqoff1, irqoff4;
  logic [7:0]  rd1, rd4;
  int          leak;

  sb_reg_slave #(.DATA_W(8), .BASE_NIB(4'h0), .NUM_REGS(4), .ACK_LAT(1),
                 .RST_VAL(8'h00)) u_dut1 (
    .SBCLKi(clk), .RST(rst_n), .SBWRi(sbwr), .SBSTBi(sbstb), .SBADRi(sbadr),
    .SBDATi(sbdat), .SBDATo(dato1), .SBACKo(ack1), .IRQ(irq1), .CTRL_O(ctrl1),
    .STATUS_I(status_i), .EVT_I(evt1), .dbg_state(st1)
  );

  sb_reg_slave #(.DATA_W(8), .BASE_NIB(4'h0), .NUM_REGS(4), .ACK_LAT(4),
                 .RST_VAL(8'h00)) u_dut4 (
    .SBCLKi(clk), .RST(rst_n), .SBWRi(sbwr), .SBSTBi(sbstb), .SBADRi(sbadr),
    .SBDATi(sbdat), .SBDATo(dato4), .SBACKo(ack4), .IRQ(irq4), .CTRL_O(ctrl4),
    .STATUS_I(status_i), .EVT_I(evt4), .dbg_state(st4)
  );

  // Clock and watchdog.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // One bus transaction; observes both instances for 20 cycles after the
  // strobe edge. Strobe drops after the first cycle. restrobe raises a
  // second strobe edge while the slow instance waits; evt_commit pulses
  // EVT_I[0] in the cycle each instance commits its write.
  task automatic xfer(input logic wr, input logic [7:0] adr, input logic [7:0] dat,
                      input bit restrobe, input bit evt_commit);
    @(posedge clk); #1;
    sbwr = wr; sbadr = adr; sbdat = dat; sbstb = 1'b1;
    @(posedge clk);
    lat1 = 0; lat4 = 0; cnt1 = 0; cnt4 = 0; rd1 = 8'h00; rd4 = 8'h00;
    irqoff1 = 0; irqoff4 = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (ack1) begin
        cnt1++;
        if (lat1 == 0) begin lat1 = k; rd1 = dato1; end
      end else if (dato1 != 8'h00) leak++;
      if (ack4) begin
        cnt4++;
        if (lat4 == 0) begin lat4 = k; rd4 = dato4; end
      end else if (dato4 != 8'h00) leak++;
      if (!irq1 && irqoff1 == 0) irqoff1 = k;
      if (!irq4 && irqoff4 == 0) irqoff4 = k;
      if (k == 1) sbstb = 1'b0;
      if (restrobe && k == 2) sbstb = 1'b1;
      if (restrobe && k == 3) sbstb = 1'b0;
      if (evt_commit) begin
        evt1 = (k == 1) ? 8'h01 : 8'h00;
        evt4 = (k == 4) ? 8'h01 : 8'h00;
      end
    end
  endtask

  // Standard checks for a transaction acked once by each instance.
  task automatic chk_acked(input string tag, input logic [7:0] exp_rd);
    check({tag, ".lat1"}, 32'(lat1), 32'd1);
    check({tag, ".lat4"}, 32'(lat4), 32'd4);
    check({tag, ".cnt1"}, 32'(cnt1), 32'd1);
    check({tag, ".cnt4"}, 32'(cnt4), 32'd1);
    check({tag, ".rd1"},  32'(rd1),  32'(exp_rd));
    check({tag, ".rd4"},  32'(rd4),  32'(exp_rd));
  endtask

  task automatic pulse_evt();
    @(posedge clk); #1;
    evt1 = 8'h01; evt4 = 8'h01;
    @(posedge clk); #1;
    evt1 = 8'h00; evt4 = 8'h00;
  endtask

  initial begin
    int n4;
    checks = 0; errors = 0; leak = 0;
    rst_n = 1'b0; sbwr = 1'b0; sbstb = 1'b0; sbadr = 8'h00; sbdat = 8'h00;
    status_i = 8'h00; evt1 = 8'h00; evt4 = 8'h00;

    // Reset state.
    repeat (3) @(negedge clk);
    check("rst.ack1", 32'(ack1), 32'd0);
    check("rst.ack4", 32'(ack4), 32'd0);
    check("rst.dato1", 32'(dato1), 32'd0);
    check("rst.irq1", 32'(irq1), 32'd0);
    check("rst.irq4", 32'(irq4), 32'd0);
    check("rst.ctrl1", ctrl1, 32'h0);
    check("rst.ctrl4", ctrl4, 32'h0);
    check("rst.st4", 32'(st4), 32'd0);
    rst_n = 1'b1;

    // Write 0xA5 to reg 1; old value 0 is on SBDATo during the ack.
    xfer(1'b1, 8'h01, 8'hA5, 1'b0, 1'b0);
    chk_acked("wr01", 8'h00);
    check("wr01.ctrl1", ctrl1, 32'h0000A500);
    check("wr01.ctrl4", ctrl4, 32'h0000A500);

    // Read reg 1.
    xfer(1'b0, 8'h01, 8'h00, 1'b0, 1'b0);
    chk_acked("rd01", 8'hA5);

    // Wrong base nibble: no ack at all.
    xfer(1'b1, 8'h12, 8'h55, 1'b0, 1'b0);
    check("dec12.cnt1", 32'(cnt1), 32'd0);
    check("dec12.cnt4", 32'(cnt4), 32'd0);
    check("dec12.ctrl1", ctrl1, 32'h0000A500);

    // Unmapped offset: acked, reads 0, write ignored.
    xfer(1'b1, 8'h07, 8'h77, 1'b0, 1'b0);
    chk_acked("wr07", 8'h00);
    check("wr07.ctrl1", ctrl1, 32'h0000A500);
    check("wr07.ctrl4", ctrl4, 32'h0000A500);
    xfer(1'b0, 8'h07, 8'h00, 1'b0, 1'b0);
    chk_acked("rd07", 8'h00);

    // IEN write/read.
    xfer(1'b1, 8'h0D, 8'h01, 1'b0, 1'b0);
    chk_acked("wr0d", 8'h00);
    xfer(1'b0, 8'h0D, 8'h00, 1'b0, 1'b0);
    chk_acked("rd0d", 8'h01);

    // Event sets PEND and IRQ rises the edge it is sampled.
    check("pre_evt.irq1", 32'(irq1), 32'd0);
    pulse_evt();
    check("evt.irq1", 32'(irq1), 32'd1);
    check("evt.irq4", 32'(irq4), 32'd1);
    xfer(1'b0, 8'h0F, 8'h00, 1'b0, 1'b0);
    chk_acked("rd0f", 8'h01);

    // W1C: IRQ falls one edge after the ack cycle.
    xfer(1'b1, 8'h0F, 8'h01, 1'b0, 1'b0);
    chk_acked("w1c", 8'h01);
    check("w1c.irqoff1", 32'(irqoff1), 32'd2);
    check("w1c.irqoff4", 32'(irqoff4), 32'd5);
    xfer(1'b0, 8'h0F, 8'h00, 1'b0, 1'b0);
    chk_acked("rd0f_clr", 8'h00);

    // Event on the clear edge wins: PEND[0] and IRQ stay set.
    pulse_evt();
    xfer(1'b1, 8'h0F, 8'h01, 1'b0, 1'b1);
    chk_acked("setwin", 8'h01);
    check("setwin.irq1", 32'(irq1), 32'd1);
    check("setwin.irq4", 32'(irq4), 32'd1);
    xfer(1'b0, 8'h0F, 8'h00, 1'b0, 1'b0);
    chk_acked("setwin.rd", 8'h01);
    xfer(1'b1, 8'h0F, 8'h01, 1'b0, 1'b0);
    check("clr2.irq1", 32'(irq1), 32'd0);
    check("clr2.irq4", 32'(irq4), 32'd0);

    // Second strobe edge during WAIT: slow instance acks once; the fast one
    // is already idle and treats it as a new transaction.
    xfer(1'b1, 8'h02, 8'h5A, 1'b1, 1'b0);
    check("restb.lat4", 32'(lat4), 32'd4);
    check("restb.cnt4", 32'(cnt4), 32'd1);
    check("restb.cnt1", 32'(cnt1), 32'd2);
    check("restb.ctrl1", ctrl1, 32'h005AA500);
    check("restb.ctrl4", ctrl4, 32'h005AA500);

    // STATUS is read-only.
    status_i = 8'h3C;
    xfer(1'b0, 8'h0E, 8'h00, 1'b0, 1'b0);
    chk_acked("rd0e", 8'h3C);
    xfer(1'b1, 8'h0E, 8'hFF, 1'b0, 1'b0);
    chk_acked("wr0e", 8'h3C);
    xfer(1'b0, 8'h0E, 8'h00, 1'b0, 1'b0);
    chk_acked("rd0e2", 8'h3C);

    // Reset while the slow instance is waiting: no ack, registers reset.
    @(posedge clk); #1;
    sbwr = 1'b1; sbadr = 8'h03; sbdat = 8'h99; sbstb = 1'b1;
    @(posedge clk);
    @(negedge clk); sbstb = 1'b0;
    @(negedge clk);
    check("rstw.st4_wait", 32'(st4), 32'd1);
    rst_n = 1'b0;
    #1;
    check("rstw.st4_idle", 32'(st4), 32'd0);
    check("rstw.ack4", 32'(ack4), 32'd0);
    @(negedge clk); rst_n = 1'b1;
    n4 = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (ack4) n4++;
    end
    check("rstw.noack4", 32'(n4), 32'd0);
    check("rstw.ctrl4", ctrl4, 32'h0);
    check("rstw.ctrl1", ctrl1, 32'h0);
    check("rstw.st4_end", 32'(st4), 32'd0);

    // SBDATo must have been 0 in every non-ack cycle observed.
    check("dato_idle_zero", 32'(leak), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
